// File: rtl/level_sequencer_fsm_pkg.sv
// Shared types and width helpers for the level sequencer and the drawers
// that consume its level code.
package level_pkg;

  // Game-progress states. Encodings 5..7 are unused and recover to ARM.
  typedef enum logic [2:0] {
    ST_ARM       = 3'd0,
    ST_PLAY      = 3'd1,
    ST_TRANS     = 3'd2,
    ST_WIN       = 3'd3,
    ST_GAME_OVER = 3'd4
  } lvl_state_t;

  // Level code of the first playable level, shared with the level-select muxes.
  localparam int FIRST_LEVEL = 0;

  // Width of the level index. Never narrower than one bit.
  function automatic int lvlWidth(input int numLevels);
    return (numLevels <= 2) ? 1 : $clog2(numLevels);
  endfunction

  // Width of the lives counter. It must be able to hold LIVES itself, not just LIVES-1.
  function automatic int lifeWidth(input int lives);
    return (lives <= 1) ? 1 : $clog2(lives + 1);
  endfunction

  // Width of a counter that runs 0..n-1.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/level_sequencer_fsm_edge_rise_det.sv
// One-bit registered rising-edge detector. The history register follows the
// input every cycle. The rise output is registered, so it appears one cycle
// after the clock edge that first samples the input high.
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  // Track the previous input level and register the rise condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= level_i;
      rise_q <= level_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/level_sequencer_fsm.sv
// Game-progress controller: arms after reset or restart, runs the playable
// levels with a lives counter, and inserts a timed transition window after
// each level-up or retry. WIN and GAME_OVER are left only by a restart request
// or a reset. All outputs are registered.
module level_sequencer_fsm
  import level_pkg::*;
#(
  parameter int NUM_LEVELS   = 4,
  parameter int LIVES        = 3,
  parameter int ARM_CYCLES   = 2,
  parameter int TRANS_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            playerDied,
  input  logic                            finishFlag,
  input  logic                            restartReq,
  output logic [lvlWidth(NUM_LEVELS)-1:0] levelCode,
  output logic [lifeWidth(LIVES)-1:0]     livesLeft,
  output logic                            levelUp,
  output logic                            levelRestart,
  output logic                            inTransition,
  output logic                            win,
  output logic                            gameOver
);

  localparam int LVL_W   = lvlWidth(NUM_LEVELS);
  localparam int LIFE_W  = lifeWidth(LIVES);
  localparam int ARM_W   = cntWidth(ARM_CYCLES);
  localparam int TRANS_W = cntWidth(TRANS_CYCLES);

  localparam logic [LVL_W-1:0]   LVL_FIRST  = LVL_W'(FIRST_LEVEL);
  localparam logic [LVL_W-1:0]   LVL_LAST   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0]   LVL_ONE    = LVL_W'(1);
  localparam logic [LIFE_W-1:0]  LIFE_INIT  = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0]  LIFE_ONE   = LIFE_W'(1);
  localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_CYCLES - 1);
  localparam logic [ARM_W-1:0]   ARM_ONE    = ARM_W'(1);
  localparam logic [TRANS_W-1:0] TRANS_LAST = TRANS_W'(TRANS_CYCLES - 1);
  localparam logic [TRANS_W-1:0] TRANS_ONE  = TRANS_W'(1);

  lvl_state_t state_q, state_d;
  lvl_state_t sampledState_q;

  logic [ARM_W-1:0]   armCnt_q, armCnt_d;
  logic [TRANS_W-1:0] transCnt_q, transCnt_d;
  logic [LVL_W-1:0]   levelCode_q, levelCode_d;
  logic [LIFE_W-1:0]  livesLeft_q, livesLeft_d;
  logic               levelUp_q, levelUp_d;
  logic               levelRestart_q, levelRestart_d;
  logic               inTransition_q, inTransition_d;
  logic               win_q, win_d;
  logic               gameOver_q, gameOver_d;

  logic diedRiseRaw, finishRiseRaw, restartRiseRaw;
  logic riseValid;
  logic diedRise, finishRise, restartRise;

  edge_rise_det diedDet (
    .clk     (clk),
    .reset   (reset),
    .level_i (playerDied),
    .rise_o  (diedRiseRaw)
  );

  edge_rise_det finishDet (
    .clk     (clk),
    .reset   (reset),
    .level_i (finishFlag),
    .rise_o  (finishRiseRaw)
  );

  edge_rise_det restartDet (
    .clk     (clk),
    .reset   (reset),
    .level_i (restartReq),
    .rise_o  (restartRiseRaw)
  );

  // A registered rise belongs to the state the FSM was in when the input was
  // sampled. Act on it only if the FSM is still in that state. A rise caught
  // during ARM or TRANS then cannot leak into the first PLAY cycle.
  always_comb begin
    riseValid   = (sampledState_q == state_q);
    diedRise    = diedRiseRaw & riseValid;
    finishRise  = finishRiseRaw & riseValid;
    restartRise = restartRiseRaw & riseValid;
  end

  // Next-state, counter and output logic. Death takes priority over finish.
  always_comb begin
    state_d        = state_q;
    armCnt_d       = armCnt_q;
    transCnt_d     = transCnt_q;
    levelCode_d    = levelCode_q;
    livesLeft_d    = livesLeft_q;
    levelUp_d      = 1'b0;
    levelRestart_d = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (armCnt_q == ARM_LAST) begin
          armCnt_d = '0;
          state_d  = ST_PLAY;
        end else begin
          armCnt_d = armCnt_q + ARM_ONE;
        end
      end

      ST_PLAY: begin
        if (diedRise) begin
          if (livesLeft_q > LIFE_ONE) begin
            livesLeft_d    = livesLeft_q - LIFE_ONE;
            levelRestart_d = 1'b1;
            transCnt_d     = '0;
            state_d        = ST_TRANS;
          end else begin
            livesLeft_d = '0;
            state_d     = ST_GAME_OVER;
          end
        end else if (finishRise) begin
          if (levelCode_q < LVL_LAST) begin
            levelCode_d = levelCode_q + LVL_ONE;
            levelUp_d   = 1'b1;
            transCnt_d  = '0;
            state_d     = ST_TRANS;
          end else begin
            state_d = ST_WIN;
          end
        end
      end

      ST_TRANS: begin
        if (transCnt_q == TRANS_LAST) begin
          transCnt_d = '0;
          state_d    = ST_PLAY;
        end else begin
          transCnt_d = transCnt_q + TRANS_ONE;
        end
      end

      ST_WIN, ST_GAME_OVER: begin
        if (restartRise) begin
          levelCode_d = LVL_FIRST;
          livesLeft_d = LIFE_INIT;
          armCnt_d    = '0;
          transCnt_d  = '0;
          state_d     = ST_ARM;
        end
      end

      default: begin
        state_d     = ST_ARM;
        armCnt_d    = '0;
        transCnt_d  = '0;
        levelCode_d = LVL_FIRST;
        livesLeft_d = LIFE_INIT;
      end
    endcase

    inTransition_d = (state_d == ST_TRANS);
    win_d          = (state_d == ST_WIN);
    gameOver_d     = (state_d == ST_GAME_OVER);
  end

  // State, counters and registered outputs. Reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ARM;
      sampledState_q <= ST_ARM;
      armCnt_q       <= '0;
      transCnt_q     <= '0;
      levelCode_q    <= LVL_FIRST;
      livesLeft_q    <= LIFE_INIT;
      levelUp_q      <= 1'b0;
      levelRestart_q <= 1'b0;
      inTransition_q <= 1'b0;
      win_q          <= 1'b0;
      gameOver_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sampledState_q <= state_q;
      armCnt_q       <= armCnt_d;
      transCnt_q     <= transCnt_d;
      levelCode_q    <= levelCode_d;
      livesLeft_q    <= livesLeft_d;
      levelUp_q      <= levelUp_d;
      levelRestart_q <= levelRestart_d;
      inTransition_q <= inTransition_d;
      win_q          <= win_d;
      gameOver_q     <= gameOver_d;
    end
  end

  assign levelCode    = levelCode_q;
  assign livesLeft    = livesLeft_q;
  assign levelUp      = levelUp_q;
  assign levelRestart = levelRestart_q;
  assign inTransition = inTransition_q;
  assign win          = win_q;
  assign gameOver     = gameOver_q;

endmodule

// File: doc/level_sequencer_fsm.md
Name: level_sequencer_fsm

Overview:
Parametrised game-progress controller and next generation of the two-level FSM. It sequences NUM_LEVELS levels, tracks a lives counter with retry-on-death, and inserts a timed transition window between levels. It supports restart from WIN or GAME_OVER without a hardware reset. It sits between the collision/finish detectors and the level-select muxes, background drawer and HUD.

Parameters:
NUM_LEVELS, 4, number of playable levels (>=2); level codes run 0..NUM_LEVELS-1.
LIVES, 3, lives at start and after restart (>=1).
ARM_CYCLES, 2, post-reset/restart blanking cycles during which inputs are ignored (>=1).
TRANS_CYCLES, 16, length of the transition window after level-up or retry (>=1).

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
playerDied  in  1  level signal from the collision logic; only its rising edge is used.
finishFlag  in  1  level signal, player reached the level exit; only its rising edge is used.
restartReq  in  1  level signal from the key or button; only its rising edge is used.
levelCode  out  LVL_W  current level index; LVL_W = max(1, $clog2(NUM_LEVELS)).
livesLeft  out  LIFE_W  remaining lives; LIFE_W = $clog2(LIVES+1).
levelUp  out  1  one-cycle pulse on advancing to the next level.
levelRestart  out  1  one-cycle pulse on retrying the same level after a death.
inTransition  out  1  high throughout the TRANS window.
win  out  1  high while in WIN.
gameOver  out  1  high while in GAME_OVER.

Behaviour:
- States: ARM, PLAY, TRANS, WIN, GAME_OVER. All outputs are registered.
- Reset values: state=ARM, armCnt=0, transCnt=0, levelCode=0, livesLeft=LIVES, all pulses and flags 0, edge-detect history registers=0.
- Edge detect: x_rise = x & ~x_prev. The x_prev registers update every cycle in every state, including ARM. An input held high through ARM therefore produces no edge when ARM exits.
- ARM: armCnt counts 0..ARM_CYCLES-1. On the cycle armCnt==ARM_CYCLES-1 the FSM goes to PLAY. All rises are ignored.
- PLAY, priority playerDied_rise > finishFlag_rise (a simultaneous death and finish counts as a death):
  - death with livesLeft>1: livesLeft-1, levelRestart=1 for 1 cycle, go to TRANS, levelCode unchanged.
  - death with livesLeft==1: livesLeft=0, go to GAME_OVER.
  - finish with levelCode<NUM_LEVELS-1: levelCode+1, levelUp=1 for 1 cycle, go to TRANS.
  - finish with levelCode==NUM_LEVELS-1: go to WIN; levelCode holds and never wraps.
  - restartReq is ignored in PLAY.
- Latency: an edge sampled at clock edge t makes the state, levelCode, livesLeft and the pulse visible after edge t+1 (one-cycle registered response).
- TRANS: inTransition=1. transCnt counts 0..TRANS_CYCLES-1, then the FSM returns to PLAY. All rises are ignored; history registers still track.
- WIN / GAME_OVER: terminal. win or gameOver is held high. On restartReq_rise: levelCode=0, livesLeft=LIVES, counters cleared, go to ARM. playerDied and finishFlag are ignored.
- reset asserted at any point, mid-TRANS or mid-ARM included, forces the reset values immediately (asynchronous). Operation resumes via ARM after reset deasserts.
- levelUp and levelRestart are never high in the same cycle. Neither pulse lasts longer than one cycle.
- Illegal or unused state encodings recover to ARM with reset values.

Decomposition:
- Package level_pkg holds: the state enum typedef (lvl_state_t), width helper functions or localparams for LVL_W and LIFE_W, and code constants used by the drawers (FIRST_LEVEL=0).
- Sub-module edge_rise_det: one-bit registered rising-edge detector with clk and reset. It is instantiated three times, once each for playerDied, finishFlag and restartReq.

Test Plan:
1. Reset behaviour (NUM_LEVELS=4, ARM_CYCLES=2): assert reset, then release with finishFlag held high. Required: levelCode=0, livesLeft=3, no levelUp ever, PLAY reached 2 cycles after release.
2. Full progression (TRANS_CYCLES=4): finish pulses on levels 0, 1 and 2. Required: levelCode steps 1, 2, 3, each step with a single-cycle levelUp and 4 cycles of inTransition. A fourth finish gives win=1 and levelCode stays 3.
3. Lives exhaustion (LIVES=3): playerDied pulses on level 2. Required: livesLeft steps 2 then 1, each with levelRestart, levelCode stays 2. The third death gives livesLeft=0, gameOver=1, and no levelRestart pulse.
4. Simultaneous events: playerDied and finishFlag rise in the same cycle on level 1 with livesLeft=2. Required: livesLeft=1, levelRestart=1, levelUp=0, levelCode=1. Rises during TRANS are ignored.
5. Restart: from GAME_OVER, pulse restartReq. Required: levelCode=0, livesLeft=3, gameOver=0, state ARM, then PLAY. A restartReq pulse during PLAY has no effect.
6. Asynchronous reset mid-TRANS (transCnt=2). Required: all outputs at reset values immediately without waiting for a clock edge; inTransition=0.
